// File: rtl/traffic_lamp_if.sv
// Lamp bus between the traffic-light controller and the safety monitor.
// master = controller side (drives lamp requests, observes monitored lamps),
// slave  = monitor side.
interface traffic_lamp_if;
  logic       FM;
  logic       GRN1, YLW1, RED1;
  logic       GRN2, YLW2, RED2;
  logic       GRN1_Q, YLW1_Q, RED1_Q;
  logic       GRN2_Q, YLW2_Q, RED2_Q;
  logic       FAULT;
  logic [2:0] FAULT_CODE;

  modport master (
    output FM, GRN1, YLW1, RED1, GRN2, YLW2, RED2,
    input  GRN1_Q, YLW1_Q, RED1_Q, GRN2_Q, YLW2_Q, RED2_Q, FAULT, FAULT_CODE
  );

  modport slave (
    input  FM, GRN1, YLW1, RED1, GRN2, YLW2, RED2,
    output GRN1_Q, YLW1_Q, RED1_Q, GRN2_Q, YLW2_Q, RED2_Q, FAULT, FAULT_CODE
  );
endinterface

// File: rtl/traffic_lamp_monitor.sv
// Safety monitor for a two-direction traffic-light controller.
// Stage 1 registers the lamp drives, the checkers look at the registered copy,
// stage 2 re-drives the lamps. The first detected violation latches a fault
// code and forces both directions to (optionally flashing) red until CLR.
module traffic_lamp_monitor #(
  parameter int MIN_YLW   = 3,
  parameter int MAX_GRN   = 64,
  parameter int CNT_W     = 8,
  parameter int FLASH_DIV = 4
) (
  input  logic           CK,
  input  logic           CLR,
  traffic_lamp_if.slave  bus
);

  typedef enum logic [1:0] {T_UNK, T_RED, T_GRN, T_YLW} trk_e;

  localparam logic [CNT_W-1:0] DW_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DW_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] YLW_MIN = CNT_W'(MIN_YLW);
  localparam logic [CNT_W-1:0] GRN_MAX = CNT_W'(MAX_GRN);
  localparam int               FC_W    = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'((FLASH_DIV > 0) ? FLASH_DIV - 1 : 0);

  // Only the three forward steps of the cycle are allowed.
  function automatic logic legal_move(input trk_e from_s, input trk_e to_s);
    return (from_s == T_RED && to_s == T_GRN) ||
           (from_s == T_GRN && to_s == T_YLW) ||
           (from_s == T_YLW && to_s == T_RED);
  endfunction

  // ---------------- stage 1: input capture ----------------
  // Lamp vectors are {G,Y,R}; index 0 = direction 1, index 1 = direction 2.
  logic            s_vld_q;
  logic            s_fm_q;
  logic [1:0][2:0] s_lamp_q;

  // Register the controller drives; s_vld_q masks the zeroed stage right after reset.
  always_ff @(posedge CK) begin
    if (CLR) begin
      s_vld_q  <= 1'b0;
      s_fm_q   <= 1'b0;
      s_lamp_q <= '0;
    end else begin
      s_vld_q     <= 1'b1;
      s_fm_q      <= bus.FM;
      s_lamp_q[0] <= {bus.GRN1, bus.YLW1, bus.RED1};
      s_lamp_q[1] <= {bus.GRN2, bus.YLW2, bus.RED2};
    end
  end

  // ---------------- checkers ----------------
  trk_e             trk_q [2];
  trk_e             trk_d [2];
  logic [CNT_W-1:0] dw_q  [2];
  logic [CNT_W-1:0] dw_d  [2];
  logic [1:0]       onehot, nonred, enc_bad, seq_bad, ysh_bad, gl_bad;
  logic             conf_bad;

  // Per-direction encoding, tracker next state, dwell and sequence checks.
  always_comb begin
    onehot  = '0;
    nonred  = '0;
    enc_bad = '0;
    seq_bad = '0;
    ysh_bad = '0;
    gl_bad  = '0;
    for (int d = 0; d < 2; d++) begin
      trk_d[d] = trk_q[d];
      dw_d[d]  = dw_q[d];
      onehot[d] = (s_lamp_q[d] == 3'b100) || (s_lamp_q[d] == 3'b010) ||
                  (s_lamp_q[d] == 3'b001);
      nonred[d] = s_lamp_q[d][2] | s_lamp_q[d][1];
      // All-dark is only acceptable while the controller is flashing.
      enc_bad[d] = !(onehot[d] || (s_fm_q && s_lamp_q[d] == 3'b000));
      // Flash forgets history; a bad code holds the tracker (the fault covers it).
      if (s_fm_q)
        trk_d[d] = T_UNK;
      else if (onehot[d])
        trk_d[d] = s_lamp_q[d][2] ? T_GRN : (s_lamp_q[d][1] ? T_YLW : T_RED);
      if (trk_d[d] != trk_q[d])
        dw_d[d] = DW_ONE;
      else if (dw_q[d] != DW_MAX)
        dw_d[d] = dw_q[d] + DW_ONE;
      seq_bad[d] = !s_fm_q && (trk_q[d] != T_UNK) && (trk_d[d] != trk_q[d]) &&
                   !legal_move(trk_q[d], trk_d[d]);
      ysh_bad[d] = !s_fm_q && (trk_q[d] == T_YLW) && (trk_d[d] != T_YLW) &&
                   (dw_q[d] < YLW_MIN);
      gl_bad[d]  = (trk_d[d] == T_GRN) && (dw_d[d] >= GRN_MAX);
    end
    conf_bad = !s_fm_q && nonred[0] && nonred[1];
  end

  // Trackers and dwell counters follow the registered lamps.
  always_ff @(posedge CK) begin
    if (CLR) begin
      for (int d = 0; d < 2; d++) begin
        trk_q[d] <= T_UNK;
        dw_q[d]  <= '0;
      end
    end else if (s_vld_q) begin
      for (int d = 0; d < 2; d++) begin
        trk_q[d] <= trk_d[d];
        dw_q[d]  <= dw_d[d];
      end
    end
  end

  // ---------------- fault latch ----------------
  logic [2:0] chk_code;
  logic       fault_q, fault_d;
  logic [2:0] code_q;

  // Lowest-numbered violation wins when several fire together.
  always_comb begin
    chk_code = 3'd0;
    if (s_vld_q) begin
      if (|enc_bad)      chk_code = 3'd1;
      else if (conf_bad) chk_code = 3'd2;
      else if (|seq_bad) chk_code = 3'd3;
      else if (|ysh_bad) chk_code = 3'd4;
      else if (|gl_bad)  chk_code = 3'd5;
    end
    fault_d = fault_q | (chk_code != 3'd0);
  end

  // First fault is sticky; later ones are ignored until CLR.
  always_ff @(posedge CK) begin
    if (CLR) begin
      fault_q <= 1'b0;
      code_q  <= 3'd0;
    end else if (!fault_q && chk_code != 3'd0) begin
      fault_q <= 1'b1;
      code_q  <= chk_code;
    end
  end

  // ---------------- safe-red flasher ----------------
  logic [FC_W-1:0] fc_q, fc_d;
  logic            ph_q, ph_d;
  logic            red_d;

  // Held at (0, on) until the fault, so the fault edge starts a full ON half-period.
  always_comb begin
    fc_d = '0;
    ph_d = 1'b1;
    if (fault_q) begin
      if (fc_q == FC_LAST) begin
        fc_d = '0;
        ph_d = ~ph_q;
      end else begin
        fc_d = fc_q + FC_W'(1);
        ph_d = ph_q;
      end
    end
    red_d = (FLASH_DIV == 0) ? 1'b1 : ph_d;
  end

  // Flash counter and phase.
  always_ff @(posedge CK) begin
    if (CLR) begin
      fc_q <= '0;
      ph_q <= 1'b1;
    end else begin
      fc_q <= fc_d;
      ph_q <= ph_d;
    end
  end

  // ---------------- stage 2: lamp re-drive ----------------
  logic [1:0][2:0] lamp_q;

  // Pass-through normally; safe red from the very edge the fault latches.
  always_ff @(posedge CK) begin
    if (CLR)
      lamp_q <= '0;
    else if (fault_d)
      lamp_q <= {{2'b00, red_d}, {2'b00, red_d}};
    else
      lamp_q <= s_lamp_q;
  end

  assign bus.GRN1_Q     = lamp_q[0][2];
  assign bus.YLW1_Q     = lamp_q[0][1];
  assign bus.RED1_Q     = lamp_q[0][0];
  assign bus.GRN2_Q     = lamp_q[1][2];
  assign bus.YLW2_Q     = lamp_q[1][1];
  assign bus.RED2_Q     = lamp_q[1][0];
  assign bus.FAULT      = fault_q;
  assign bus.FAULT_CODE = code_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Directed bench for traffic_lamp_monitor (MIN_YLW=3, MAX_GRN=64, FLASH_DIV=4).
// Lamp vectors are {G,Y,R}; observed word is {lamps1, lamps2, FAULT, FAULT_CODE}.
module tb_traffic_lamp_monitor;
  logic CK = 1'b0;
  logic CLR;
  traffic_lamp_if bus();

  traffic_lamp_monitor #(
    .MIN_YLW(3), .MAX_GRN(64), .CNT_W(8), .FLASH_DIV(4)
  ) dut (
    .CK (CK),
    .CLR(CLR),
    .bus(bus)
  );

  always #5 CK = ~CK;

  localparam logic [2:0] R = 3'b001, Y = 3'b010, G = 3'b100, O = 3'b000;

  int n_vec = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic set(input logic fm, input logic [2:0] l1, input logic [2:0] l2);
    bus.FM = fm;
    {bus.GRN1, bus.YLW1, bus.RED1} = l1;
    {bus.GRN2, bus.YLW2, bus.RED2} = l2;
  endtask

  task automatic apply(input logic [2:0] l1, input logic [2:0] l2);
    set(1'b0, l1, l2);
    tick();
  endtask

  function automatic logic [9:0] obs();
    return {bus.GRN1_Q, bus.YLW1_Q, bus.RED1_Q, bus.GRN2_Q, bus.YLW2_Q, bus.RED2_Q,
            bus.FAULT, bus.FAULT_CODE};
  endfunction

  function automatic logic [9:0] ok(input logic [2:0] l1, input logic [2:0] l2);
    return {l1, l2, 1'b0, 3'd0};
  endfunction

  function automatic logic [9:0] flt(input logic [2:0] code, input logic red);
    return {2'b00, red, 2'b00, red, 1'b1, code};
  endfunction

  task automatic chk(input string tag, input logic [9:0] exp);
    logic [9:0] o;
    o = obs();
    n_vec++;
    assert (o === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, o, exp);
    end
  endtask

  task automatic chk_fc(input string tag, input logic [3:0] exp);
    logic [3:0] o;
    o = {bus.FAULT, bus.FAULT_CODE};
    n_vec++;
    assert (o === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, o, exp);
    end
  endtask

  task automatic do_reset();
    CLR = 1'b1;
    set(1'b0, R, R);
    tick();
    tick();
    CLR = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] v1 [6];
    logic [2:0] v2 [6];
    v1 = '{R, R, R, R, R, G};
    v2 = '{G, Y, Y, Y, R, R};

    // 1: reset state, then legal traffic passes through with 2-cycle latency
    do_reset();
    chk("reset", 10'b0);
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) set(1'b0, v1[i], v2[i]);
      tick();
      if (i >= 1) chk($sformatf("pass%0d", i - 1), ok(v1[i - 1], v2[i - 1]));
    end

    // 2: d1 = G+R -> ENC, then safe red flashing 4 on / 4 off, code sticky
    set(1'b0, 3'b101, R);
    tick();
    chk("enc_pre", ok(G, R));
    tick();
    chk("enc_fault", flt(3'd1, 1'b1));
    set(1'b0, G, G);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("flash%0d", k), flt(3'd1, ((k / 4) % 2) == 0));
    end

    // 3: conflict G/G -> CONF; a following yellow-short is ignored
    do_reset();
    apply(G, R);
    apply(G, R);
    apply(G, G);
    chk("conf_pre", ok(G, R));
    apply(G, Y);
    chk("conf", flt(3'd2, 1'b1));
    apply(G, R);
    apply(G, R);
    chk_fc("conf_hold", {1'b1, 3'd2});

    // 3b: ENC and CONF together -> lowest code wins
    do_reset();
    apply(R, R);
    apply(3'b110, G);
    apply(R, R);
    chk("prio", flt(3'd1, 1'b1));

    // 4: yellow for 2 cycles -> YSHORT; yellow for 3 cycles -> clean
    do_reset();
    apply(R, R);
    apply(G, R);
    apply(Y, R);
    apply(Y, R);
    apply(R, R);
    chk("ysh_pre", ok(Y, R));
    apply(R, R);
    chk("yshort", flt(3'd4, 1'b1));

    do_reset();
    apply(R, R);
    apply(G, R);
    apply(Y, R);
    apply(Y, R);
    apply(Y, R);
    apply(R, R);
    apply(R, R);
    chk("y3_ok", ok(R, R));
    apply(R, R);
    chk("y3_ok2", ok(R, R));

    // 5: green held 63 captured cycles is fine, the 64th trips GLONG
    do_reset();
    apply(R, R);
    for (int k = 1; k <= 64; k++) apply(G, R);
    chk("glong_pre", ok(G, R));
    apply(G, R);
    chk("glong", flt(3'd5, 1'b1));

    // 5b: GRN -> RED directly -> SEQ
    do_reset();
    apply(G, R);
    apply(R, R);
    chk("seq_pre", ok(G, R));
    apply(R, R);
    chk("seq", flt(3'd3, 1'b1));

    // 6: flash mode with dark/yellow, then leave flash on G/R
    do_reset();
    set(1'b1, Y, Y); tick();
    set(1'b1, O, O); tick();
    chk("fm_yy", {Y, Y, 1'b0, 3'd0});
    set(1'b1, Y, Y); tick();
    chk("fm_dark", ok(O, O));
    set(1'b1, O, O); tick();
    set(1'b0, G, R); tick();
    set(1'b0, G, R); tick();
    chk("fm_exit", ok(G, R));
    apply(G, R);
    chk("fm_exit2", ok(G, R));

    // 6b: CLR in the middle of a fault clears everything on the next edge
    apply(O, R);
    apply(R, R);
    chk("dark_enc", flt(3'd1, 1'b1));
    CLR = 1'b1;
    tick();
    chk("clr_mid", 10'b0);
    CLR = 1'b0;
    apply(R, R);
    apply(R, R);
    chk("post_clr", ok(R, R));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
